// File: rtl/lab2_proc_mul_pkg.sv
// Shared types and constants for the iterative integer multiplier.
package lab2_proc_mul_pkg;

    localparam int MUL_NBITS      = 32;
    localparam int MUL_REQ_NBITS  = 2 * MUL_NBITS;
    localparam int MUL_RESP_NBITS = MUL_NBITS;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Operand register input select: keep, load from request, or shift one step
    typedef enum logic [1:0] {
        OPND_HOLD  = 2'd0,
        OPND_LOAD  = 2'd1,
        OPND_SHIFT = 2'd2
    } opnd_sel_e;

    // Result register input select: clear for a new request, or accumulate
    typedef enum logic {
        RESULT_CLEAR = 1'b0,
        RESULT_ADD   = 1'b1
    } result_sel_e;

endpackage

// File: rtl/lab2_proc_int_mul_iter_dpath.sv
// Shift-and-add datapath for the iterative multiplier: operand shifters,
// p_nbits accumulator and step counter, steered by the control FSM.
module lab2_proc_int_mul_iter_dpath
    import lab2_proc_mul_pkg::*;
#(
    parameter int p_nbits = MUL_NBITS
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [p_nbits-1:0] op_a,
    input  logic [p_nbits-1:0] op_b,
    input  opnd_sel_e          a_mux_sel,
    input  opnd_sel_e          b_mux_sel,
    input  result_sel_e        result_mux_sel,
    input  logic               result_en,
    input  logic               add_en,
    input  logic               cnt_clr,
    output logic               b_lsb,
    output logic               cnt_last,
    output logic [p_nbits-1:0] result
);

    localparam int CW = $clog2(p_nbits);
    localparam logic [CW-1:0] CNT_LAST = CW'(p_nbits - 1);

    logic [p_nbits-1:0] a_reg, b_reg, result_reg;
    logic [p_nbits-1:0] a_next, b_next, result_next, sum;
    logic [CW-1:0]      cnt;

    // Next-value muxes; the adder is exactly p_nbits wide so carry-out wraps away
    always_comb begin
        a_next = a_reg;
        b_next = b_reg;
        case (a_mux_sel)
            OPND_LOAD:  a_next = op_a;
            OPND_SHIFT: a_next = a_reg << 1;
            default:    a_next = a_reg;
        endcase
        case (b_mux_sel)
            OPND_LOAD:  b_next = op_b;
            OPND_SHIFT: b_next = b_reg >> 1;
            default:    b_next = b_reg;
        endcase
        sum         = result_reg + (add_en ? a_reg : '0);
        result_next = (result_mux_sel == RESULT_ADD) ? sum : '0;
    end

    // Datapath registers; the counter advances in lockstep with the b shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            cnt        <= '0;
        end else begin
            a_reg <= a_next;
            b_reg <= b_next;
            if (result_en)
                result_reg <= result_next;
            if (cnt_clr)
                cnt <= '0;
            else if (b_mux_sel == OPND_SHIFT)
                cnt <= cnt + 1'b1;
        end
    end

    assign b_lsb    = b_reg[0];
    assign cnt_last = (cnt == CNT_LAST);
    assign result   = result_reg;

endmodule

// File: rtl/lab2_proc_int_mul_iter.sv
// Iterative multiplier with val/rdy handshakes: returns the low p_nbits of
// op_a*op_b after exactly p_nbits shift-and-add steps.
module lab2_proc_int_mul_iter
    import lab2_proc_mul_pkg::*;
#(
    parameter int p_nbits = MUL_NBITS
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [2*p_nbits-1:0] req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [p_nbits-1:0]   resp_msg
);

    mul_state_e  state, state_next;
    opnd_sel_e   a_mux_sel, b_mux_sel;
    result_sel_e result_mux_sel;
    logic        result_en, add_en, cnt_clr;
    logic        b_lsb, cnt_last;

    // State register; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state, Moore handshake outputs and datapath controls
    always_comb begin
        state_next     = state;
        req_rdy        = 1'b0;
        resp_val       = 1'b0;
        a_mux_sel      = OPND_HOLD;
        b_mux_sel      = OPND_HOLD;
        result_mux_sel = RESULT_CLEAR;
        result_en      = 1'b0;
        add_en         = 1'b0;
        cnt_clr        = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    a_mux_sel      = OPND_LOAD;
                    b_mux_sel      = OPND_LOAD;
                    result_mux_sel = RESULT_CLEAR;
                    result_en      = 1'b1;
                    cnt_clr        = 1'b1;
                    state_next     = CALC;
                end
            end
            CALC: begin
                a_mux_sel      = OPND_SHIFT;
                b_mux_sel      = OPND_SHIFT;
                result_mux_sel = RESULT_ADD;
                result_en      = 1'b1;
                add_en         = b_lsb;
                if (cnt_last)
                    state_next = DONE;
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    lab2_proc_int_mul_iter_dpath #(
        .p_nbits (p_nbits)
    ) dpath (
        .clk            (clk),
        .reset          (reset),
        .op_a           (req_msg[2*p_nbits-1:p_nbits]),
        .op_b           (req_msg[p_nbits-1:0]),
        .a_mux_sel      (a_mux_sel),
        .b_mux_sel      (b_mux_sel),
        .result_mux_sel (result_mux_sel),
        .result_en      (result_en),
        .add_en         (add_en),
        .cnt_clr        (cnt_clr),
        .b_lsb          (b_lsb),
        .cnt_last       (cnt_last),
        .result         (resp_msg)
    );

endmodule

// File: tb/tb_lab2_proc_int_mul_iter.sv
// Self-checking bench for the iterative multiplier: directed cases plus
// randomized operands and handshake delays against a plain-arithmetic model.
module tb_lab2_proc_int_mul_iter;

    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_val;
    logic          req_rdy;
    logic [2*NB-1:0] req_msg;
    logic          resp_val;
    logic          resp_rdy;
    logic [NB-1:0] resp_msg;

    int checks = 0;
    int errors = 0;

    lab2_proc_int_mul_iter #(.p_nbits(NB)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Golden model: full product truncated to the low 32 bits
    function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = 64'(a) * 64'(b);
        return full[31:0];
    endfunction

    // Waits for resp_val with a cycle bound; returns cycles waited since the accept edge
    task automatic waitResp(output int n, output logic busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (!resp_val && n < 100) begin
            if (req_rdy !== 1'b0) busy_ok = 1'b0;
            tick();
            n++;
        end
    endtask

    // One complete transaction with request/response delays and full checking
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input int req_dly, input int rsp_dly, input string tag);
        logic [31:0] exp;
        int          n;
        logic        busy_ok;
        exp = refMul(a, b);
        repeat (req_dly) tick();
        checkOutput({tag, "_idle_rdy"}, 32'(req_rdy), 32'd1);
        req_val = 1'b1;
        req_msg = {a, b};
        tick();
        req_val = 1'b0;
        req_msg = {$urandom, $urandom};
        waitResp(n, busy_ok);
        checkOutput({tag, "_latency"}, 32'(n), 32'(NB));
        checkOutput({tag, "_busy_rdy"}, 32'(busy_ok), 32'd1);
        for (int i = 0; i < rsp_dly; i++) begin
            checkOutput({tag, "_stall_val"}, 32'(resp_val), 32'd1);
            checkOutput({tag, "_stall_msg"}, resp_msg, exp);
            checkOutput({tag, "_stall_rdy"}, 32'(req_rdy), 32'd0);
            tick();
        end
        checkOutput({tag, "_result"}, resp_msg, exp);
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        checkOutput({tag, "_post_rdy"}, 32'(req_rdy), 32'd1);
        checkOutput({tag, "_post_val"}, 32'(resp_val), 32'd0);
    endtask

    initial begin
        int   n;
        logic busy_ok;
        logic saw_resp;
        logic [31:0] ra, rb;

        reset    = 1'b1;
        req_val  = 1'b0;
        req_msg  = '0;
        resp_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_req_rdy", 32'(req_rdy), 32'd1);
        checkOutput("reset_resp_val", 32'(resp_val), 32'd0);
        checkOutput("reset_resp_msg", resp_msg, 32'd0);

        // Basic and wrap-around cases
        applyStimulus(32'd3, 32'd4, 0, 0, "basic");
        checkOutput("basic_const", refMul(32'd3, 32'd4), 32'h0000000c);
        applyStimulus(32'hffffffff, 32'hffffffff, 0, 0, "neg1sq");
        applyStimulus(32'h80000000, 32'h00000002, 0, 0, "wrap0");
        applyStimulus(32'hfffffffd, 32'h00000005, 0, 0, "neg3x5");

        // Downstream backpressure for 10 cycles
        applyStimulus(32'h00001234, 32'h00000567, 1, 10, "bkpr");

        // Back-to-back with req_val held high; second message sits on the bus during CALC
        req_val = 1'b1;
        req_msg = {32'h00001234, 32'h00005678};
        tick();
        req_msg = {32'h00000000, 32'hdeadbeef};
        waitResp(n, busy_ok);
        checkOutput("b2b1_latency", 32'(n), 32'(NB));
        checkOutput("b2b1_result", resp_msg, 32'h06260060);
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        checkOutput("b2b_gap_rdy", 32'(req_rdy), 32'd1);
        tick();
        req_val = 1'b0;
        checkOutput("b2b2_accepted", 32'(req_rdy), 32'd0);
        waitResp(n, busy_ok);
        checkOutput("b2b2_latency", 32'(n), 32'(NB));
        checkOutput("b2b2_result", resp_msg, 32'h00000000);
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;

        // Reset 10 cycles into CALC drops the operation
        req_val = 1'b1;
        req_msg = {32'd7, 32'd9};
        tick();
        req_val = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_mid_rdy", 32'(req_rdy), 32'd1);
        checkOutput("rst_mid_val", 32'(resp_val), 32'd0);
        saw_resp = 1'b0;
        repeat (40) begin
            if (resp_val !== 1'b0) saw_resp = 1'b1;
            tick();
        end
        checkOutput("rst_mid_no_resp", 32'(saw_resp), 32'd0);
        applyStimulus(32'd7, 32'd9, 0, 0, "after_rst");
        checkOutput("after_rst_const", refMul(32'd7, 32'd9), 32'h0000003f);

        // Reset wins over a simultaneous request
        reset   = 1'b1;
        req_val = 1'b1;
        req_msg = {32'd5, 32'd6};
        tick();
        reset   = 1'b0;
        req_val = 1'b0;
        checkOutput("rst_vs_req_rdy", 32'(req_rdy), 32'd1);
        checkOutput("rst_vs_req_val", 32'(resp_val), 32'd0);

        // Random operands and handshake delays
        for (int i = 0; i < 500; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'hffffffff;
                1: rb = 32'h80000000;
                2: rb = 32'd0;
                default: ;
            endcase
            applyStimulus(ra, rb, $urandom_range(0, 5), $urandom_range(0, 5), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
